uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1024, idle-mid-frame cycles before a locked grant is revoked (used only with UART_ARB_TIMEOUT_EN).
REQ-002 Port: FAB_CLK  input  1  fabric clock; all state on rising edge.
REQ-003 Port: MSS_RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: REQ0_DATA  input  8  requester 0 byte.
REQ-005 Port: REQ0_VALID  input  1  requester 0 byte valid.
REQ-006 Port: REQ0_LAST  input  1  requester 0 byte is final byte of frame.
REQ-007 Port: REQ0_READY  output  1  requester 0 byte accepted this cycle when VALID also high.
REQ-008 Port: REQ1_DATA/REQ1_VALID/REQ1_LAST/REQ1_READY  same directions/widths  requester 1 equivalents.
REQ-009 Port: TX_DATA  output  8  byte to UART TX channel.
REQ-010 Port: TX_VALID  output  1  TX_DATA valid.
REQ-011 Port: TX_READY  input  1  UART TX channel accepts byte when TX_VALID high.
REQ-012 Port: GNT  output  2  one-hot current grant (bit n = requester n); 2'b00 in IDLE.
REQ-013 Port: TIMEOUT_ERR  output  1  one-cycle pulse on grant revocation by timeout.

Function
REQ-014 FSM SHALL have states IDLE, GRANT0, GRANT1; GNT decodes state combinationally.
REQ-015 IDLE: if exactly one REQn_VALID high, next state GRANTn; if both high, grant the requester not served last (round-robin pointer); if none, stay IDLE.
REQ-016 Arbitration SHALL cost one cycle: VALID sampled in IDLE at edge N -> GRANTn after edge N; REQn_READY may assert from cycle N+1.
REQ-017 REQn_READY SHALL equal (state==GRANTn) && (!TX_VALID || TX_READY); the non-granted READY SHALL be 0.
REQ-018 Accepted byte (VALID&&READY at edge N) SHALL appear on TX_DATA with TX_VALID=1 after edge N (latency 1), one-entry output register.
REQ-019 TX_VALID SHALL clear after edge where TX_VALID&&TX_READY with no new byte accepted; back-to-back acceptance sustains one byte per cycle while TX_READY=1.
REQ-020 TX_DATA SHALL hold stable while TX_VALID=1 and TX_READY=0.
REQ-021 Grant SHALL be locked for the whole frame: GRANTn exits to IDLE only after the edge accepting a byte with REQn_LAST=1 (or timeout); round-robin pointer set to n at that edge.
REQ-022 Single-byte frame (first byte has LAST=1) SHALL return to IDLE after one acceptance.
REQ-023 Other requester's VALID during a locked frame SHALL be ignored (no preemption); it wins next arbitration.
REQ-024 Output register draining SHALL NOT block arbitration: a new grant may be issued while TX_VALID=1, READY gated per REQ-017.

Reset
REQ-025 MSS_RESET_N low SHALL asynchronously force: state IDLE, GNT=0, TX_VALID=0, TX_DATA=8'h00, REQ0_READY=REQ1_READY=0, TIMEOUT_ERR=0, timeout counter 0, pointer = requester 1 (so requester 0 wins first tie).
REQ-026 Reset mid-frame SHALL drop any byte in the output register and the partial frame; no recovery of it.
REQ-027 Reset deassertion SHALL be used synchronized externally; block makes no release-synchronization of its own.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN defined: counter increments each cycle in GRANTn with REQn_VALID=0, clears on any acceptance; on reaching TIMEOUT_CYCLES state -> IDLE, pointer=n, TIMEOUT_ERR pulses 1 cycle; pending output byte still drains.
REQ-029 Macro undefined: no counter, TIMEOUT_ERR tied 0, grant held indefinitely until LAST.

Verification
REQ-030 Single requester: REQ0 sends 3'h frame 0x41,0x42,0x43(LAST), TX_READY=1 -> TX_DATA 0x41,0x42,0x43 on consecutive cycles, GNT=01 then 00.
REQ-031 Tie: both VALID from reset, REQ0 frame 0x10(LAST), REQ1 frame 0x20(LAST) -> 0x10 then 0x20; repeat tie -> order alternates.
REQ-032 Lock: REQ0 4-byte frame, REQ1 VALID asserted mid-frame -> REQ1_READY stays 0 until REQ0 LAST accepted; no interleaving on TX_DATA.
REQ-033 Backpressure: TX_READY=0 for 5 cycles mid-frame -> TX_DATA stable, REQ0_READY=0, no byte lost or duplicated after release.
REQ-034 Reset mid-frame after 2 of 4 bytes -> all outputs at REQ-025 values immediately; post-reset REQ1 frame granted normally.
REQ-035 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: REQ1 stalls VALID after first byte -> TIMEOUT_ERR pulse at 8th idle cycle, GNT=00, waiting REQ0 granted next.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART TX handshake bundle for uart_tx_arbiter
// Purpose: groups both requester byte streams, the UART TX byte stream and the
//          grant/status outputs of uart_tx_arbiter into one port.
// Modports:
//   master - environment side: drives REQn_DATA/VALID/LAST and TX_READY
//   slave  - arbiter side: drives REQn_READY, TX_DATA/TX_VALID, GNT, TIMEOUT_ERR
interface uart_tx_arbiter_if;
  logic [7:0] REQ0_DATA;
  logic       REQ0_VALID;
  logic       REQ0_LAST;
  logic       REQ0_READY;
  logic [7:0] REQ1_DATA;
  logic       REQ1_VALID;
  logic       REQ1_LAST;
  logic       REQ1_READY;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic [1:0] GNT;
  logic       TIMEOUT_ERR;

  modport master (
    output REQ0_DATA, REQ0_VALID, REQ0_LAST, REQ1_DATA, REQ1_VALID, REQ1_LAST, TX_READY,
    input  REQ0_READY, REQ1_READY, TX_DATA, TX_VALID, GNT, TIMEOUT_ERR
  );

  modport slave (
    input  REQ0_DATA, REQ0_VALID, REQ0_LAST, REQ1_DATA, REQ1_VALID, REQ1_LAST, TX_READY,
    output REQ0_READY, REQ1_READY, TX_DATA, TX_VALID, GNT, TIMEOUT_ERR
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester frame-locked round-robin arbiter feeding a UART TX channel
// Purpose: grants one of two byte-stream requesters for a whole frame (until a
//          byte with LAST is accepted) and forwards accepted bytes through a
//          one-entry output register to the UART TX channel.
// Ports:
//   FAB_CLK     - fabric clock, all state on rising edge
//   MSS_RESET_N - asynchronous active-low reset (release synchronized externally)
//   bus         - uart_tx_arbiter_if.slave: requester streams, TX stream, GNT, TIMEOUT_ERR
// Parameter:
//   TIMEOUT_CYCLES - idle-mid-frame cycles before a locked grant is revoked
// Optional feature: define UART_ARB_TIMEOUT_EN to enable grant revocation on
//   timeout; otherwise TIMEOUT_ERR is tied low and a grant is held until LAST.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic              FAB_CLK,
  input logic              MSS_RESET_N,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;          // requester served last; the other wins a tie
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;

  logic       out_free;
  logic       ready0, ready1;
  logic       acc0, acc1, accept, acc_last;
  logic [7:0] acc_data;
  logic [1:0] gnt;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_err_q, tmo_err_d;
  logic          grant_valid;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b1;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_err_q  <= tmo_err_d;
`endif
    end
  end

  // Next-state and datapath logic
  always_comb begin
    acc0     = ready0 && bus.REQ0_VALID;
    acc1     = ready1 && bus.REQ1_VALID;
    accept   = acc0 || acc1;
    acc_data = acc1 ? bus.REQ1_DATA : bus.REQ0_DATA;
    acc_last = acc1 ? bus.REQ1_LAST : bus.REQ0_LAST;

    state_d    = state_q;
    ptr_d      = ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    // One-entry output register: refill on accept, otherwise drain on TX_READY.
    if (accept) begin
      tx_data_d  = acc_data;
      tx_valid_d = 1'b1;
    end else if (bus.TX_READY) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.REQ0_VALID && bus.REQ1_VALID) state_d = ptr_q ? GRANT0 : GRANT1;
        else if (bus.REQ0_VALID)              state_d = GRANT0;
        else if (bus.REQ1_VALID)              state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (accept && acc_last) begin
          state_d = IDLE;
          ptr_d   = (state_q == GRANT1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    grant_valid = (state_q == GRANT1) ? bus.REQ1_VALID : bus.REQ0_VALID;
    cnt_d       = cnt_q;
    tmo_err_d   = 1'b0;
    // Count only cycles where the granted requester has nothing to offer;
    // a stalled TX channel with VALID high is not the requester's fault.
    if (state_q == IDLE || accept) begin
      cnt_d = '0;
    end else if (!grant_valid) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = IDLE;
        ptr_d     = (state_q == GRANT1);
        tmo_err_d = 1'b1;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // Output decode
  always_comb begin
    out_free = !tx_valid_q || bus.TX_READY;
    ready0   = (state_q == GRANT0) && out_free;
    ready1   = (state_q == GRANT1) && out_free;
    gnt      = 2'b00;
    case (state_q)
      GRANT0:  gnt = 2'b01;
      GRANT1:  gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign bus.REQ0_READY = ready0;
  assign bus.REQ1_READY = ready1;
  assign bus.TX_DATA    = tx_data_q;
  assign bus.TX_VALID   = tx_valid_q;
  assign bus.GNT        = gnt;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.TIMEOUT_ERR = tmo_err_q;
`else
  assign bus.TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .FAB_CLK     (clk),
    .MSS_RESET_N (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [7:0] d, input logic l);
    bus.REQ0_VALID = v; bus.REQ0_DATA = d; bus.REQ0_LAST = l;
  endtask

  task automatic drive1(input logic v, input logic [7:0] d, input logic l);
    bus.REQ1_VALID = v; bus.REQ1_DATA = d; bus.REQ1_LAST = l;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive0(0, 8'h00, 0);
    drive1(0, 8'h00, 0);
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    drive0(0, 8'h00, 0);
    drive1(0, 8'h00, 0);
    bus.TX_READY = 1'b1;
    rst_n = 1'b0;
    tick; tick;
    n_total++; if (bus.GNT !== 2'b00) $display("FAIL rst_gnt got %b want 00", bus.GNT); else n_pass++;
    n_total++; if (bus.TX_VALID !== 1'b0) $display("FAIL rst_tx_valid got %b want 0", bus.TX_VALID); else n_pass++;
    n_total++; if (bus.TX_DATA !== 8'h00) $display("FAIL rst_tx_data got %h want 00", bus.TX_DATA); else n_pass++;
    n_total++; if ({bus.REQ1_READY, bus.REQ0_READY} !== 2'b00) $display("FAIL rst_ready got %b want 00", {bus.REQ1_READY, bus.REQ0_READY}); else n_pass++;
    n_total++; if (bus.TIMEOUT_ERR !== 1'b0) $display("FAIL rst_tmo got %b want 0", bus.TIMEOUT_ERR); else n_pass++;
    rst_n = 1'b1;
    tick;
    n_total++; if (bus.GNT !== 2'b00) $display("FAIL idle_gnt got %b want 00", bus.GNT); else n_pass++;
  endtask

  task automatic test_single;
    drive0(1, 8'h41, 0);
    n_total++; if (bus.REQ0_READY !== 1'b0) $display("FAIL single_arb_ready got %b want 0", bus.REQ0_READY); else n_pass++;
    tick;
    n_total++; if (bus.GNT !== 2'b01) $display("FAIL single_gnt got %b want 01", bus.GNT); else n_pass++;
    n_total++; if (bus.REQ0_READY !== 1'b1) $display("FAIL single_ready got %b want 1", bus.REQ0_READY); else n_pass++;
    tick;
    n_total++; if ({bus.TX_VALID, bus.TX_DATA} !== {1'b1, 8'h41}) $display("FAIL single_b0 got %b/%h want 1/41", bus.TX_VALID, bus.TX_DATA); else n_pass++;
    drive0(1, 8'h42, 0);
    tick;
    n_total++; if ({bus.TX_VALID, bus.TX_DATA} !== {1'b1, 8'h42}) $display("FAIL single_b1 got %b/%h want 1/42", bus.TX_VALID, bus.TX_DATA); else n_pass++;
    drive0(1, 8'h43, 1);
    tick;
    n_total++; if ({bus.TX_VALID, bus.TX_DATA} !== {1'b1, 8'h43}) $display("FAIL single_b2 got %b/%h want 1/43", bus.TX_VALID, bus.TX_DATA); else n_pass++;
    n_total++; if (bus.GNT !== 2'b00) $display("FAIL single_gnt_end got %b want 00", bus.GNT); else n_pass++;
    drive0(0, 8'h00, 0);
    tick;
    n_total++; if (bus.TX_VALID !== 1'b0) $display("FAIL single_drain got %b want 0", bus.TX_VALID); else n_pass++;
  endtask

  task automatic test_tie;
    logic [1:0] exp_gnt;
    logic [7:0] exp_data;
    do_reset;
    drive0(1, 8'h10, 1);
    drive1(1, 8'h20, 1);
    for (int i = 0; i < 4; i++) begin
      exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (i % 2 == 0) ? 8'h10 : 8'h20;
      tick;
      n_total++; if (bus.GNT !== exp_gnt) $display("FAIL tie_gnt%0d got %b want %b", i, bus.GNT, exp_gnt); else n_pass++;
      tick;
      n_total++; if ({bus.TX_VALID, bus.TX_DATA, bus.GNT} !== {1'b1, exp_data, 2'b00}) $display("FAIL tie_data%0d got %b/%h/%b want 1/%h/00", i, bus.TX_VALID, bus.TX_DATA, bus.GNT, exp_data); else n_pass++;
    end
    drive0(0, 8'h00, 0);
    drive1(0, 8'h00, 0);
    tick;
  endtask

  task automatic test_lock;
    logic [7:0] frame [4];
    frame[0] = 8'hA0; frame[1] = 8'hA1; frame[2] = 8'hA2; frame[3] = 8'hA3;
    drive0(1, frame[0], 0);
    tick;
    n_total++; if (bus.GNT !== 2'b01) $display("FAIL lock_gnt got %b want 01", bus.GNT); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (i == 0) drive1(1, 8'hB0, 1);
      n_total++; if (bus.TX_DATA !== frame[i]) $display("FAIL lock_data%0d got %h want %h", i, bus.TX_DATA, frame[i]); else n_pass++;
      n_total++; if (bus.REQ1_READY !== 1'b0) $display("FAIL lock_ready1_%0d got %b want 0", i, bus.REQ1_READY); else n_pass++;
      if (i < 3) drive0(1, frame[i+1], (i == 2));
      else       drive0(0, 8'h00, 0);
    end
    n_total++; if (bus.GNT !== 2'b00) $display("FAIL lock_gnt_end got %b want 00", bus.GNT); else n_pass++;
    tick;
    n_total++; if ({bus.GNT, bus.REQ1_READY} !== {2'b10, 1'b1}) $display("FAIL lock_next got %b/%b want 10/1", bus.GNT, bus.REQ1_READY); else n_pass++;
    tick;
    n_total++; if (bus.TX_DATA !== 8'hB0) $display("FAIL lock_b0 got %h want b0", bus.TX_DATA); else n_pass++;
    drive1(0, 8'h00, 0);
    tick;
  endtask

  task automatic test_backpressure;
    drive0(1, 8'hC0, 0);
    tick;
    tick;
    n_total++; if (bus.TX_DATA !== 8'hC0) $display("FAIL bp_c0 got %h want c0", bus.TX_DATA); else n_pass++;
    drive0(1, 8'hC1, 0);
    bus.TX_READY = 1'b0;
    #1;
    n_total++; if (bus.REQ0_READY !== 1'b0) $display("FAIL bp_ready got %b want 0", bus.REQ0_READY); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_total++; if ({bus.TX_VALID, bus.TX_DATA, bus.REQ0_READY} !== {1'b1, 8'hC0, 1'b0}) $display("FAIL bp_hold%0d got %b/%h/%b want 1/c0/0", i, bus.TX_VALID, bus.TX_DATA, bus.REQ0_READY); else n_pass++;
    end
    bus.TX_READY = 1'b1;
    tick;
    n_total++; if (bus.TX_DATA !== 8'hC1) $display("FAIL bp_c1 got %h want c1", bus.TX_DATA); else n_pass++;
    drive0(1, 8'hC2, 0);
    tick;
    n_total++; if (bus.TX_DATA !== 8'hC2) $display("FAIL bp_c2 got %h want c2", bus.TX_DATA); else n_pass++;
    drive0(1, 8'hC3, 1);
    tick;
    n_total++; if ({bus.TX_DATA, bus.GNT} !== {8'hC3, 2'b00}) $display("FAIL bp_c3 got %h/%b want c3/00", bus.TX_DATA, bus.GNT); else n_pass++;
    drive0(0, 8'h00, 0);
    tick;
    n_total++; if (bus.TX_VALID !== 1'b0) $display("FAIL bp_drain got %b want 0", bus.TX_VALID); else n_pass++;
  endtask

  task automatic test_reset_mid;
    drive0(1, 8'hD0, 0);
    tick;
    tick;
    drive0(1, 8'hD1, 0);
    tick;
    n_total++; if (bus.TX_DATA !== 8'hD1) $display("FAIL rmid_d1 got %h want d1", bus.TX_DATA); else n_pass++;
    drive0(1, 8'hD2, 0);
    rst_n = 1'b0;
    #1;
    n_total++; if ({bus.GNT, bus.TX_VALID, bus.TX_DATA} !== {2'b00, 1'b0, 8'h00}) $display("FAIL rmid_out got %b/%b/%h want 00/0/00", bus.GNT, bus.TX_VALID, bus.TX_DATA); else n_pass++;
    n_total++; if ({bus.REQ1_READY, bus.REQ0_READY, bus.TIMEOUT_ERR} !== 3'b000) $display("FAIL rmid_rdy got %b want 000", {bus.REQ1_READY, bus.REQ0_READY, bus.TIMEOUT_ERR}); else n_pass++;
    drive0(0, 8'h00, 0);
    tick;
    rst_n = 1'b1;
    drive1(1, 8'hE0, 1);
    #1;
    n_total++; if (bus.REQ1_READY !== 1'b0) $display("FAIL rmid_arb got %b want 0", bus.REQ1_READY); else n_pass++;
    tick;
    n_total++; if (bus.GNT !== 2'b10) $display("FAIL rmid_gnt got %b want 10", bus.GNT); else n_pass++;
    tick;
    n_total++; if ({bus.TX_DATA, bus.GNT} !== {8'hE0, 2'b00}) $display("FAIL rmid_e0 got %h/%b want e0/00", bus.TX_DATA, bus.GNT); else n_pass++;
    drive1(0, 8'h00, 0);
    tick;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout;
    drive1(1, 8'hF0, 0);
    tick;
    drive0(1, 8'h60, 1);
    tick;
    n_total++; if (bus.TX_DATA !== 8'hF0) $display("FAIL tmo_f0 got %h want f0", bus.TX_DATA); else n_pass++;
    drive1(0, 8'h00, 0);
    for (int i = 1; i < 8; i++) begin
      tick;
      n_total++; if ({bus.GNT, bus.TIMEOUT_ERR} !== {2'b10, 1'b0}) $display("FAIL tmo_wait%0d got %b/%b want 10/0", i, bus.GNT, bus.TIMEOUT_ERR); else n_pass++;
    end
    tick;
    n_total++; if ({bus.GNT, bus.TIMEOUT_ERR} !== {2'b00, 1'b1}) $display("FAIL tmo_fire got %b/%b want 00/1", bus.GNT, bus.TIMEOUT_ERR); else n_pass++;
    tick;
    n_total++; if ({bus.GNT, bus.TIMEOUT_ERR} !== {2'b01, 1'b0}) $display("FAIL tmo_next got %b/%b want 01/0", bus.GNT, bus.TIMEOUT_ERR); else n_pass++;
    tick;
    n_total++; if (bus.TX_DATA !== 8'h60) $display("FAIL tmo_60 got %h want 60", bus.TX_DATA); else n_pass++;
    drive0(0, 8'h00, 0);
    tick;
  endtask
`else
  task automatic test_hold;
    drive1(1, 8'h70, 0);
    tick;
    tick;
    n_total++; if (bus.TX_DATA !== 8'h70) $display("FAIL hold_70 got %h want 70", bus.TX_DATA); else n_pass++;
    drive1(0, 8'h00, 0);
    drive0(1, 8'h71, 1);
    for (int i = 0; i < 20; i++) begin
      tick;
      n_total++; if ({bus.GNT, bus.REQ0_READY, bus.TIMEOUT_ERR} !== {2'b10, 1'b0, 1'b0}) $display("FAIL hold_wait%0d got %b/%b/%b want 10/0/0", i, bus.GNT, bus.REQ0_READY, bus.TIMEOUT_ERR); else n_pass++;
    end
    drive1(1, 8'h72, 1);
    tick;
    n_total++; if ({bus.TX_DATA, bus.GNT} !== {8'h72, 2'b00}) $display("FAIL hold_72 got %h/%b want 72/00", bus.TX_DATA, bus.GNT); else n_pass++;
    drive1(0, 8'h00, 0);
    tick;
    n_total++; if (bus.GNT !== 2'b01) $display("FAIL hold_next got %b want 01", bus.GNT); else n_pass++;
    tick;
    n_total++; if (bus.TX_DATA !== 8'h71) $display("FAIL hold_71 got %h want 71", bus.TX_DATA); else n_pass++;
    drive0(0, 8'h00, 0);
    tick;
  endtask
`endif

  initial begin
    bus.TX_READY = 1'b1;
    test_reset;
    test_single;
    test_tie;
    test_lock;
    test_backpressure;
    test_reset_mid;
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout;
`else
    test_hold;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
